// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - per-frame ship, scroll, collision, lives and phase sequencer
// All game state advances on frame_tick; collide pulses between ticks are latched.
module game_sequencer #(
   parameter int SCREEN_W    = 800,
   parameter int SHIP_SIZE   = 20,
   parameter int SHIP_STEP   = 2,
   parameter int OBJ_STEP    = 5,
   parameter int SCROLL_WRAP = 650,
   parameter int LIVES       = 3,
   parameter int HIT_FRAMES  = 60
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_frame_tick,
   input  logic       i_move_left,
   input  logic       i_move_right,
   input  logic       i_start,
   input  logic       i_collide,
   output logic [9:0] o_ship_x,
   output logic [9:0] o_scroll,
   output logic [2:0] o_lives,
   output logic [1:0] o_state,
   output logic       o_ship_visible,
   output logic       o_hit_pulse
);

   localparam int         X_MAX_I      = SCREEN_W - SHIP_SIZE;
   localparam logic [9:0] C_X_MAX      = 10'(X_MAX_I);
   localparam logic [9:0] C_X_HOME     = 10'(X_MAX_I / 2);
   localparam logic [9:0] C_SHIP_STEP  = 10'(SHIP_STEP);
   localparam logic [9:0] C_X_RLIM     = 10'(X_MAX_I - SHIP_STEP);
   localparam logic [10:0] C_OBJ_STEP  = 11'(OBJ_STEP);
   localparam logic [10:0] C_WRAP      = 11'(SCROLL_WRAP);
   localparam logic [2:0] C_LIVES      = 3'(LIVES);
   localparam logic [7:0] C_HIT_FRAMES = 8'(HIT_FRAMES);

   typedef enum logic [1:0] {
      ST_ATTRACT = 2'd0,
      ST_PLAY    = 2'd1,
      ST_HIT     = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   state_t      r_state;
   logic [9:0]  r_ship_x;
   logic [9:0]  r_scroll;
   logic [2:0]  r_lives;
   logic [7:0]  r_timer;
   logic        r_latch;
   logic        r_hit_pulse;
   logic        r_ship_visible;

   logic [9:0]  w_ship_moved;
   logic [10:0] w_scroll_sum;
   logic [9:0]  w_scroll_next;
   logic [7:0]  w_timer_dec;
   logic        w_hit;

   // Both buttons together cancel out; position saturates at either edge.
   always_comb begin
      w_ship_moved = r_ship_x;
      if (i_move_left && !i_move_right) begin
         w_ship_moved = (r_ship_x < C_SHIP_STEP) ? 10'd0 : r_ship_x - C_SHIP_STEP;
      end else if (i_move_right && !i_move_left) begin
         w_ship_moved = (r_ship_x > C_X_RLIM) ? C_X_MAX : r_ship_x + C_SHIP_STEP;
      end
   end

   always_comb begin
      w_scroll_sum  = {1'b0, r_scroll} + C_OBJ_STEP;
      w_scroll_next = (w_scroll_sum >= C_WRAP) ? 10'd0 : w_scroll_sum[9:0];
      w_timer_dec   = r_timer - 8'd1;
      w_hit         = r_latch | i_collide;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= ST_ATTRACT;
         r_ship_x       <= C_X_HOME;
         r_scroll       <= 10'd0;
         r_lives        <= C_LIVES;
         r_timer        <= 8'd0;
         r_latch        <= 1'b0;
         r_hit_pulse    <= 1'b0;
         r_ship_visible <= 1'b1;
      end else begin
         r_hit_pulse <= 1'b0;
         if (i_frame_tick) begin
            r_latch <= 1'b0;
            case (r_state)
               ST_ATTRACT, ST_OVER: begin
                  if (i_start) begin
                     r_state        <= ST_PLAY;
                     r_lives        <= C_LIVES;
                     r_ship_x       <= C_X_HOME;
                     r_scroll       <= 10'd0;
                     r_timer        <= 8'd0;
                     r_ship_visible <= 1'b1;
                  end else if (r_state == ST_ATTRACT) begin
                     r_scroll <= w_scroll_next;
                  end
               end
               ST_PLAY: begin
                  r_ship_x <= w_ship_moved;
                  r_scroll <= w_scroll_next;
                  if (w_hit) begin
                     r_hit_pulse <= 1'b1;
                     r_lives     <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                     if (r_lives <= 3'd1) begin
                        r_state        <= ST_OVER;
                        r_ship_visible <= 1'b1;
                     end else begin
                        r_state        <= ST_HIT;
                        r_timer        <= C_HIT_FRAMES;
                        r_ship_visible <= ~C_HIT_FRAMES[3];
                     end
                  end
               end
               ST_HIT: begin
                  r_ship_x <= w_ship_moved;
                  r_scroll <= w_scroll_next;
                  r_timer  <= w_timer_dec;
                  // Blink follows timer bit 3 of the value the next frame will show.
                  if (w_timer_dec == 8'd0) begin
                     r_state        <= ST_PLAY;
                     r_ship_visible <= 1'b1;
                  end else begin
                     r_ship_visible <= ~w_timer_dec[3];
                  end
               end
               default: r_state <= ST_ATTRACT;
            endcase
         end else if (i_collide && r_state == ST_PLAY) begin
            r_latch <= 1'b1;
         end
      end
   end

   assign o_ship_x       = r_ship_x;
   assign o_scroll       = r_scroll;
   assign o_lives        = r_lives;
   assign o_state        = r_state;
   assign o_ship_visible = r_ship_visible;
   assign o_hit_pulse    = r_hit_pulse;

endmodule
